// File: rtl/sipo_receiver.sv
// Serial-in, parallel-out receiver: assembles MSB-first words of WIDTH bits and
// presents them on a valid/ready output register with a sticky overrun flag.
module sipo_receiver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SW    = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW-1:0]    shift_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             overrun_q;

    logic [WIDTH-1:0] word_d;
    logic             complete_d;
    logic             xfer_d;

    // Only WIDTH-1 bits are stored: the last bit comes straight from sin on the completing edge.
    assign word_d     = {shift_q, sin};
    assign complete_d = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign xfer_d     = valid_q && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= SW'(sin);
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q <= word_d[SW-1:0];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (complete_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A finished word lands only if the output slot is free or being drained this edge.
            if (complete_d) begin
                if (!valid_q || ready) begin
                    data_q  <= word_d;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (xfer_d) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter: WIDTH, 32, serial word length in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  marks the cycle in which sin carries the MSB of a new word.
REQ-005 Port: sin  input  1  serial data, MSB first, one bit per clk cycle.
REQ-006 Port: ready  input  1  downstream accepts data_out this cycle.
REQ-007 Port: data_out  output  WIDTH  last fully received word.
REQ-008 Port: valid  output  1  data_out holds an unconsumed word.
REQ-009 Port: busy  output  1  a word is partially received.
REQ-010 Port: overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-012 In IDLE, on a clk edge with start=1, the block SHALL load sin into the shift register LSB, set the bit count to 1, and enter SHIFT.
REQ-013 In IDLE with start=0, shift register and bit count SHALL hold.
REQ-014 In SHIFT, each edge SHALL shift left one place, insert sin at the LSB, and increment the bit count.
REQ-015 start SHALL be ignored in SHIFT, with no effect on count or data.
REQ-016 The edge sampling the WIDTH-th bit (count WIDTH-1 -> WIDTH) SHALL complete the word and return the FSM to IDLE.
REQ-017 Latency: the start edge plus WIDTH-1 further edges; the word SHALL be visible on data_out immediately after the completing edge.
REQ-018 The first bit sampled SHALL become data_out[WIDTH-1]; the last SHALL become data_out[0].
REQ-019 The block SHALL accept start on the edge immediately after a completing edge, so back-to-back words need no gap cycle.
REQ-020 The valid/ready handshake: a transfer occurs on an edge where valid=1 and ready=1.
REQ-021 valid SHALL stay 1 and data_out SHALL stay stable until a transfer occurs.
REQ-022 On a transfer edge with no completing word, valid SHALL go to 0 and data_out SHALL hold its value.
REQ-023 On a completing edge with valid=0, or with a transfer on the same edge, data_out SHALL load the new word and valid SHALL be 1.
REQ-024 On a completing edge with valid=1 and ready=0, the new word SHALL be discarded, data_out SHALL be unchanged, and overrun SHALL be set to 1.
REQ-025 overrun SHALL stay 1 until reset.
REQ-026 ready SHALL have no effect while valid=0.
REQ-027 sin SHALL be ignored in IDLE unless start=1.

Reset
REQ-028 While reset=1, the block SHALL asynchronously force state=IDLE, bit count=0, shift register=0, data_out=0, valid=0, busy=0, overrun=0, without waiting for clk.
REQ-029 Reset asserted mid-word SHALL discard the partial word; the first start after reset deasserts SHALL begin a fresh word.
REQ-030 start sampled on the first edge after reset deasserts SHALL be honoured.

Verification
REQ-031 Reset, ready=1; start with sin = 0xA5A5F00F MSB first over 32 edges -> valid=1 with data_out=0xA5A5F00F after edge 32; valid=0 after edge 33; busy=1 on edges 1..31 only.
REQ-032 Back-to-back words 0x12345678 then 0xFFFF0000, second start on the edge after completion, ready=1 -> both words delivered in order, overrun=0.
REQ-033 ready=0; receive 0x0000000F then 0xDEADBEEF -> data_out=0x0000000F, valid=1, overrun=1 after second completion; raise ready -> one transfer, valid=0, overrun stays 1.
REQ-034 Word completes on the same edge that ready=1 consumes the previous word 0x11111111 -> data_out=new word, valid stays 1, overrun=0.
REQ-035 Assert reset asynchronously after 10 bits -> all outputs 0 before the next clk edge; then receive 0x80000001 -> data_out=0x80000001.
REQ-036 Hold start=1 for the whole word 0x0F0F0F0F -> exactly one word captured, data_out=0x0F0F0F0F; start stays ignored until the FSM is back in IDLE.
